// File: rtl/ahb_app_arbiter.sv
// Round-robin sharing of one AHB-Lite master application port among NUM_REQ
// requesters: grants last a whole transfer sequence, and responses go back to the beat's issuer.
module ahb_app_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BUSY_MAX = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [5*NUM_REQ-1:0]   req_opcode,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     beat_ack,
  output logic [31:0]            rdata,
  output logic [NUM_REQ-1:0]     rvalid,
  output logic [NUM_REQ-1:0]     err,
  output logic [4:0]             m_opcode,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_data_in,
  output logic                   m_enable,
  output logic                   m_busy,
  input  logic                   m_wait,
  input  logic [31:0]            m_data_out,
  input  logic                   m_data_valid,
  input  logic                   m_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BUSY_MAX + 1);

  typedef enum logic [2:0] {IDLE, OWN, HOLD, DRAIN, ERRW} state_t;

  state_t            state;
  state_t            nxt;
  logic [IW-1:0]     own;
  logic [IW-1:0]     downer;
  logic [IW-1:0]     last;
  logic [IW-1:0]     pick;
  logic              pick_vld;
  logic              first;
  logic              accept;
  logic [31:0]       wbuf;
  logic [31:0]       addr_hold;
  logic [4:0]        opc_hold;
  logic [BW-1:0]     bcnt;
  logic [3:0]        own_opc;
  logic [31:0]       own_addr;
  logic [31:0]       own_wdata;
  logic              own_req;
  logic              own_last;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign own_opc   = req_opcode[5*int'(own) +: 4];
  assign own_addr  = req_addr[32*int'(own) +: 32];
  assign own_wdata = req_wdata[32*int'(own) +: 32];
  assign own_req   = req[own];
  assign own_last  = req_last[own];

  assign m_data_in = wbuf;
  assign rdata     = m_data_out;
  assign rvalid    = m_data_valid ? onehot(downer) : '0;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && req[(int'(last) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick     = IW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    nxt      = state;
    m_enable = 1'b0;
    m_busy   = 1'b0;
    m_addr   = '0;
    m_opcode = '0;
    beat_ack = '0;
    err      = '0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) nxt = OWN;
      end
      OWN: begin
        m_enable = 1'b1;
        m_addr   = own_addr;
        m_opcode = {first, own_opc};
        if (!m_wait) begin
          if (own_req) begin
            accept        = 1'b1;
            beat_ack[own] = 1'b1;
            if (own_last) nxt = DRAIN;
          end else begin
            nxt = HOLD;
          end
        end
      end
      HOLD: begin
        m_addr   = addr_hold;
        m_opcode = opc_hold;
        if (bcnt == BW'(BUSY_MAX)) begin
          err[own] = 1'b1;
          nxt      = IDLE;
        end else begin
          m_enable = 1'b1;
          m_busy   = 1'b1;
          if (own_req) nxt = OWN;
        end
      end
      DRAIN: begin
        if (!m_wait) nxt = IDLE;
      end
      ERRW: begin
        if (!m_error) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // A master error overrides any beat or timeout in the same cycle.
    if (m_error && state != ERRW) begin
      nxt         = ERRW;
      m_enable    = 1'b0;
      m_busy      = 1'b0;
      beat_ack    = '0;
      accept      = 1'b0;
      err         = '0;
      err[downer] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      own       <= '0;
      downer    <= '0;
      last      <= IW'(NUM_REQ - 1);
      first     <= 1'b1;
      wbuf      <= '0;
      addr_hold <= '0;
      opc_hold  <= '0;
      bcnt      <= '0;
      gnt       <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == OWN) begin
        own   <= pick;
        last  <= pick;
        first <= 1'b1;
        gnt   <= onehot(pick);
      end else if (nxt == IDLE || nxt == ERRW) begin
        gnt <= '0;
      end
      if (accept) begin
        wbuf   <= own_wdata;
        downer <= own;
        first  <= 1'b0;
      end
      // The address phase shown during BUSY is the one last driven while owning.
      if (state == OWN) begin
        addr_hold <= m_addr;
        opc_hold  <= m_opcode;
      end
      if (state == OWN && nxt == HOLD) bcnt <= '0;
      else if (state == HOLD)          bcnt <= bcnt + BW'(1);
    end
  end

endmodule

// File: doc/ahb_app_arbiter.md
# ahb_app_arbiter

Shares one AHB-Lite master's application interface among `NUM_REQ` requesters. Arbitration is round-robin, and a grant is held for the requester's whole transfer sequence, including incrementing bursts. The block also does the following:
- forces the new-transfer opcode bit on the first beat of each sequence;
- registers write data into the master's data phase;
- routes read data, valid and error back to the requester that issued each beat.

It sits between the application clients and the master's `opcode/addr/data_in/enable/busy` port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `BUSY_MAX`, 8, consecutive BUSY cycles tolerated before forced release (≥1)
- `HCLK` in 1, system clock, all logic on rising edge
- `HRESETn` in 1, asynchronous active-low reset
- `req` in `NUM_REQ`, requester i has a beat to issue
- `req_opcode` in 5×`NUM_REQ`, packed per requester; bit4 ignored, bits[3:0] = {INCR, WRITE, SIZE[1:0]}
- `req_addr` in 32×`NUM_REQ`, beat address
- `req_wdata` in 32×`NUM_REQ`, write data belonging to the current beat
- `req_last` in `NUM_REQ`, current beat is the final beat of the sequence
- `gnt` out `NUM_REQ`, one-hot grant
- `beat_ack` out `NUM_REQ`, beat accepted this cycle
- `rdata` out 32, read data
- `rvalid` out `NUM_REQ`, `rdata` valid for requester i
- `err` out `NUM_REQ`, one-cycle error pulse to requester i
- `m_opcode` out 5, to master `opcode`
- `m_addr` out 32, to master `addr`
- `m_data_in` out 32, to master `data_in`
- `m_enable` out 1, to master `enable`
- `m_busy` out 1, to master `busy`
- `m_wait` in 1, from master `WAIT`
- `m_data_out` in 32, from master
- `m_data_valid` in 1, from master
- `m_error` in 1, from master

## Operation
States: `IDLE`, `OWN`, `HOLD`, `DRAIN`, `ERRW`.

- **Reset:**
  - All outputs are 0.
  - `gnt` = 0. Round-robin pointer `last` = `NUM_REQ`-1, so requester 0 has highest priority first.
  - `own`, `downer` and `wbuf` cleared. `first` = 1.
- **IDLE:**
  - If any `req` is high, pick the first set index searching from `last`+1, modulo `NUM_REQ`.
  - Register `gnt`/`own`, set `last`=`own` and `first`=1, then go to `OWN`.
- **OWN:**
  - `m_enable`=1 and `m_busy`=0.
  - `m_addr`=`req_addr[own]`.
  - `m_opcode`={`first`, `req_opcode[own]`[3:0]}.
- **Beat accept:**
  - Condition: state `OWN` && `req[own]` && !`m_wait`.
  - Effects: `beat_ack[own]`=1 (combinational), `wbuf`<=`req_wdata[own]`, `downer`<=`own`, `first`<=0.
  - If `req_last[own]`, go to `DRAIN`.
- **HOLD:**
  - In `OWN` with `req[own]`=0 and !`m_wait`, go to `HOLD`.
  - In `HOLD`: `m_enable`=1, `m_busy`=1, `m_addr`/`m_opcode` held, and `bcnt` increments.
  - `req[own]`=1 returns to `OWN`. `bcnt` is cleared on entry to `HOLD`.
  - If `bcnt` reaches `BUSY_MAX`: `err[own]` pulse, `m_enable`=0, clear `gnt`, go to `IDLE`.
- **DRAIN:**
  - `m_enable`=0.
  - Wait for `m_wait`=0, which completes the last data phase.
  - Then clear `gnt` and go to `IDLE`. A new grant may be issued the following cycle.
- **m_error, in any state:**
  - `err[downer]` pulses for one cycle.
  - Clear `gnt`, `m_enable`=0, go to `ERRW`.
  - Stay in `ERRW` until `m_error`=0, then go to `IDLE`.
- **Data return:**
  - `m_data_in`=`wbuf`, held stable while `m_wait`=1.
  - `rdata`=`m_data_out`.
  - `rvalid[downer]`=`m_data_valid`, combinational. This holds even if `gnt` has already moved to another requester.
- **Simultaneous events:**
  - `m_error` has priority over beat accept and over the `BUSY_MAX` timeout.
  - The `req` of non-owners is ignored until the grant is released.

## Timing
- Arbitration latency: `req` high in `IDLE` at edge n gives `gnt`/`m_enable` high after edge n+1.
- The first beat can be acknowledged in the cycle following the grant.
- Back-to-back beats: one `beat_ack` per cycle while `m_wait`=0.
- `m_data_in` for beat k is valid in the cycle after beat k's `beat_ack`, and is held through any `m_wait` cycles.
- `rvalid` aligns with `m_data_valid` in the same cycle, with zero added latency.
- Releasing the grant costs at least one `IDLE` cycle between owners.
- Asynchronous reset mid-burst clears everything immediately. Requesters must reissue their sequences.

## Test plan
- **Reset:** `HRESETn`=0 for 3 cycles → all outputs 0 and `gnt`=0000. Release with `req`=0 → block stays in `IDLE`.
- **3-beat incremental write by requester 0:**
  - Stimulus: `req`=0001, `req_opcode[0]`=5'b0_1110, addrs 0x100/0x104/0x108, data A/B/C, `req_last` on the third beat.
  - Response: `gnt`=0001 after one edge. `m_opcode` = 5'b1_1110 on beat 1, then 5'b0_1110.
  - Response: `m_data_in`=A, B, C one cycle after each `beat_ack`. `DRAIN` then `gnt`=0.
- **Round-robin:**
  - From reset, `req`=0101 with single-beat requests held → grant order is 0, 2, 0, 2.
  - Adding req1 after the first grant gives order 0, 1, 2.
- **Wait states:** `m_wait`=1 for 2 cycles in mid-burst → no `beat_ack`; `m_addr`, `m_opcode` and `m_data_in` unchanged. The burst resumes when `m_wait`=0.
- **Read routing:**
  - Requester 1 does a single read; `gnt` moves to requester 3.
  - Then `m_data_valid`=1 with `m_data_out`=0xDEADBEEF → `rvalid`=0010 and `rdata`=0xDEADBEEF.
- **BUSY timeout and error:**
  - Requester 2 drops `req` in mid-burst with `BUSY_MAX`=4 → `m_busy`=1 for 4 cycles, then `err`=0100 pulse and `gnt`=0.
  - Separately, `m_error`=1 during a write burst by requester 0 → `err`=0001 for one cycle, `ERRW` until `m_error`=0, then `IDLE`.
